// File: rtl/eth_csr_seq_arb_pkg.sv
// Shared constants and FSM state type for the Ethernet indirect CSR
// sequencer/arbiter (package eth_csr_pkg).
package eth_csr_pkg;

  localparam int ETH_CSR_WR_BIT = 16;
  localparam int ETH_CSR_RD_BIT = 17;
  localparam int ETH_CSR_ADDR_W = 16;
  localparam int ETH_CSR_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_WAIT,
    ST_DONE
  } t_eth_csr_state;

endpackage

// File: rtl/eth_csr_seq_arb_if.sv
// Requester-side bus of the Ethernet CSR sequencer: per-requester level
// requests with packed address/data, and the one-hot ack / read data return.
interface eth_csr_seq_arb_if
  import eth_csr_pkg::*;
#(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                req_wr;
  logic [NUM_REQ*ETH_CSR_ADDR_W-1:0] req_addr;
  logic [NUM_REQ*32-1:0]             req_wdata;
  logic [NUM_REQ-1:0]                ack;
  logic [31:0]                       ack_rdata;
  logic                              busy;

  modport master (
    output req, req_wr, req_addr, req_wdata,
    input  ack, ack_rdata, busy
  );

  modport slave (
    input  req, req_wr, req_addr, req_wdata,
    output ack, ack_rdata, busy
  );

endinterface

// File: rtl/eth_csr_rr_arb.sv
// Combinational round-robin grant: the search starts at the index after ptr
// and wraps, the first set request wins. Grant is one-hot or all-zero.
module eth_csr_rr_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  // Rotating priority search starting just past the last winner
  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx -= N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_csr_seq_arb.sv
// Sequencer/arbiter for the Ethernet MAC/PHY indirect CSR port.
// Optional build macro: ETH_CSR_ARB_PRIO_EN gives requester 0 strict priority,
// the rest are served round-robin. Without it, pure round-robin.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate and latch the winner's request
// CMD     | strobe (wr or rd) high on eth_ctrl_addr for HOLD_CYCLES
// WAIT    | strobes low, address held; RD_LAT (read) / GAP_CYCLES (write)
// DONE    | one-cycle ack to the granted requester
module eth_csr_seq_arb
  import eth_csr_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int RD_LAT      = 8,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  eth_csr_seq_arb_if.slave      bus,
  output logic [31:0]           eth_ctrl_addr,
  output logic [31:0]           eth_wr_data,
  input  logic [31:0]           eth_rd_data
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [ETH_CSR_CNT_W-1:0] HOLD_LD = ETH_CSR_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ETH_CSR_CNT_W-1:0] RD_LD   = ETH_CSR_CNT_W'(RD_LAT - 1);
  localparam logic [ETH_CSR_CNT_W-1:0] GAP_LD  = ETH_CSR_CNT_W'(GAP_CYCLES - 1);

  t_eth_csr_state           state, state_nxt;
  logic [ETH_CSR_CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0]         ptr, grant_idx, lat_idx;
  logic                     lat_wr;
  logic [NUM_REQ-1:0]       rr_req, rr_grant, grant_oh, ack_nxt;
  logic                     do_grant, end_cmd, do_capture;
  logic                     sel_wr;
  logic [31:0]              sel_wdata, cmd_word;

  eth_csr_rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .req   (rr_req),
    .ptr   (ptr),
    .grant (rr_grant)
  );

`ifdef ETH_CSR_ARB_PRIO_EN
  localparam logic [NUM_REQ-1:0] REQ0 = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign rr_req   = bus.req & ~REQ0;
  assign grant_oh = bus.req[0] ? REQ0 : rr_grant;
`else
  assign rr_req   = bus.req;
  assign grant_oh = rr_grant;
`endif

  // Encode the one-hot winner and build its command word
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_oh[i]) grant_idx = IDX_W'(i);
    end
    sel_wr    = bus.req_wr[grant_idx];
    sel_wdata = bus.req_wdata[grant_idx*32 +: 32];
    cmd_word  = '0;
    cmd_word[ETH_CSR_ADDR_W-1:0] = bus.req_addr[grant_idx*ETH_CSR_ADDR_W +: ETH_CSR_ADDR_W];
    cmd_word[ETH_CSR_WR_BIT]     = sel_wr;
    cmd_word[ETH_CSR_RD_BIT]     = ~sel_wr;
  end

  // Next-state logic with the down-counting phase timer
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    do_grant   = 1'b0;
    end_cmd    = 1'b0;
    do_capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (|bus.req) begin
          do_grant  = 1'b1;
          cnt_nxt   = HOLD_LD;
          state_nxt = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cnt == '0) begin
          end_cmd   = 1'b1;
          cnt_nxt   = lat_wr ? GAP_LD : RD_LD;
          state_nxt = ST_WAIT;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt == '0) begin
          do_capture = ~lat_wr;
          state_nxt  = ST_DONE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    ack_nxt = '0;
    if (state_nxt == ST_DONE) ack_nxt[lat_idx] = 1'b1;
  end

  // State, timer and datapath registers; every output comes straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      ptr           <= IDX_W'(NUM_REQ - 1);
      lat_wr        <= 1'b0;
      lat_idx       <= '0;
      eth_ctrl_addr <= '0;
      eth_wr_data   <= '0;
      bus.ack       <= '0;
      bus.ack_rdata <= '0;
      bus.busy      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bus.busy <= (state_nxt != ST_IDLE);
      bus.ack  <= ack_nxt;
      if (do_grant) begin
        ptr           <= grant_idx;
        lat_wr        <= sel_wr;
        lat_idx       <= grant_idx;
        eth_ctrl_addr <= cmd_word;
        eth_wr_data   <= sel_wdata;
      end
      if (end_cmd) begin
        eth_ctrl_addr[ETH_CSR_WR_BIT] <= 1'b0;
        eth_ctrl_addr[ETH_CSR_RD_BIT] <= 1'b0;
      end
      if (do_capture) bus.ack_rdata <= eth_rd_data;
    end
  end

endmodule

// File: tb/tb_eth_csr_seq_arb.sv
// Directed bench for eth_csr_seq_arb with default parameters
// (HOLD_CYCLES=4, RD_LAT=8, GAP_CYCLES=2, NUM_REQ=2).
module tb_eth_csr_seq_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] eth_ctrl_addr;
  logic [31:0] eth_wr_data;
  logic [31:0] eth_rd_data;
  int          nvec  = 0;
  int          nfail = 0;

  eth_csr_seq_arb_if #(.NUM_REQ(2)) bus ();

  eth_csr_seq_arb #(
    .NUM_REQ(2), .HOLD_CYCLES(4), .RD_LAT(8), .GAP_CYCLES(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .eth_ctrl_addr (eth_ctrl_addr),
    .eth_wr_data   (eth_wr_data),
    .eth_rd_data   (eth_rd_data)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
    nvec++; if (eth_ctrl_addr !== 32'h0) begin nfail++; $display("FAIL rst_ctrl_addr got %h exp %h", eth_ctrl_addr, 32'h0); end
    nvec++; if (eth_wr_data !== 32'h0) begin nfail++; $display("FAIL rst_wr_data got %h exp %h", eth_wr_data, 32'h0); end
    nvec++; if (bus.ack !== 2'b00) begin nfail++; $display("FAIL rst_ack got %b exp 00", bus.ack); end
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    nvec++; if (bus.ack_rdata !== 32'h0) begin nfail++; $display("FAIL rst_ack_rdata got %h exp 0", bus.ack_rdata); end
  endtask

  task automatic test_single_write;
    int lat;
    bus.req       = 2'b01;
    bus.req_wr    = 2'b01;
    bus.req_addr  = {16'h0000, 16'h0123};
    bus.req_wdata = {32'h0, 32'hDEADBEEF};
    tick;
    nvec++; if (bus.busy !== 1'b1) begin nfail++; $display("FAIL wr_busy got %b exp 1", bus.busy); end
    for (int k = 1; k <= 4; k++) begin
      nvec++; if (eth_ctrl_addr !== 32'h00010123) begin nfail++; $display("FAIL wr_strobe t+%0d got %h exp %h", k, eth_ctrl_addr, 32'h00010123); end
      tick;
    end
    nvec++; if (eth_wr_data !== 32'hDEADBEEF) begin nfail++; $display("FAIL wr_data got %h exp %h", eth_wr_data, 32'hDEADBEEF); end
    lat = 5;
    while (bus.ack === 2'b00 && lat < 40) begin
      nvec++; if (eth_ctrl_addr !== 32'h00000123) begin nfail++; $display("FAIL wr_gap t+%0d got %h exp %h", lat, eth_ctrl_addr, 32'h00000123); end
      tick; lat++;
    end
    nvec++; if (lat != 7) begin nfail++; $display("FAIL wr_ack_latency got %0d exp 7", lat); end
    nvec++; if (bus.ack !== 2'b01) begin nfail++; $display("FAIL wr_ack got %b exp 01", bus.ack); end
    bus.req = 2'b00;
    tick;
    nvec++; if (bus.ack !== 2'b00) begin nfail++; $display("FAIL wr_ack_pulse got %b exp 00", bus.ack); end
    tick;
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL wr_busy_after got %b exp 0", bus.busy); end
  endtask

  task automatic test_single_read;
    int lat;
    eth_rd_data   = 32'h0;
    bus.req       = 2'b10;
    bus.req_wr    = 2'b00;
    bus.req_addr  = {16'h0040, 16'h0000};
    bus.req_wdata = {32'h12345678, 32'h0};
    tick;
    for (int k = 1; k <= 4; k++) begin
      nvec++; if (eth_ctrl_addr !== 32'h00020040) begin nfail++; $display("FAIL rd_strobe t+%0d got %h exp %h", k, eth_ctrl_addr, 32'h00020040); end
      tick;
    end
    nvec++; if (eth_wr_data !== 32'h12345678) begin nfail++; $display("FAIL rd_wr_data got %h exp %h", eth_wr_data, 32'h12345678); end
    lat = 5;
    while (bus.ack === 2'b00 && lat < 40) begin
      if (lat == 9) eth_rd_data = 32'hCAFEF00D;
      if (lat == 12) begin
        nvec++; if (bus.ack_rdata !== 32'h0) begin nfail++; $display("FAIL rd_early_capture got %h exp 0", bus.ack_rdata); end
      end
      tick; lat++;
    end
    nvec++; if (lat != 13) begin nfail++; $display("FAIL rd_ack_latency got %0d exp 13", lat); end
    nvec++; if (bus.ack !== 2'b10) begin nfail++; $display("FAIL rd_ack got %b exp 10", bus.ack); end
    nvec++; if (bus.ack_rdata !== 32'hCAFEF00D) begin nfail++; $display("FAIL rd_data got %h exp %h", bus.ack_rdata, 32'hCAFEF00D); end
    bus.req     = 2'b00;
    eth_rd_data = 32'hBAD0BAD0;
    tick; tick; tick;
    nvec++; if (bus.ack_rdata !== 32'hCAFEF00D) begin nfail++; $display("FAIL rd_data_hold got %h exp %h", bus.ack_rdata, 32'hCAFEF00D); end
  endtask

  task automatic test_back_to_back;
    int         exp_g [4];
    logic [1:0] exp_ack;
    int         acks, cyc, last_ack, low_run;
    logic       seen;
`ifdef ETH_CSR_ARB_PRIO_EN
    exp_g = '{0, 0, 0, 0};
`else
    exp_g = '{0, 1, 0, 1};
`endif
    bus.req       = 2'b11;
    bus.req_wr    = 2'b11;
    bus.req_addr  = {16'h000B, 16'h000A};
    bus.req_wdata = {32'hBBBB0001, 32'hAAAA0000};
    acks = 0; cyc = 0; last_ack = 0; low_run = 0; seen = 1'b0;
    while (acks < 4 && cyc < 100) begin
      tick; cyc++;
      if (eth_ctrl_addr[17:16] != 2'b00) begin
        if (seen && low_run > 0) begin
          nvec++; if (low_run < 3) begin nfail++; $display("FAIL b2b_strobe_low got %0d exp >=3", low_run); end
        end
        seen    = 1'b1;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (bus.ack !== 2'b00) begin
        exp_ack = 2'b01 << exp_g[acks];
        nvec++; if (bus.ack !== exp_ack) begin nfail++; $display("FAIL b2b_grant%0d got %b exp %b", acks, bus.ack, exp_ack); end
        if (acks > 0) begin
          nvec++; if (cyc - last_ack != 8) begin nfail++; $display("FAIL b2b_period%0d got %0d exp 8", acks, cyc - last_ack); end
        end
        last_ack = cyc;
        acks++;
        if (acks == 4) bus.req = 2'b00;
      end
    end
    nvec++; if (acks != 4) begin nfail++; $display("FAIL b2b_ack_count got %0d exp 4", acks); end
    tick; tick;
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL b2b_busy_after got %b exp 0", bus.busy); end
    nvec++; if (bus.ack_rdata !== 32'hCAFEF00D) begin nfail++; $display("FAIL b2b_rdata_hold got %h exp %h", bus.ack_rdata, 32'hCAFEF00D); end
  endtask

  task automatic test_reset_mid;
    int   lat;
    logic any_ack;
    bus.req       = 2'b01;
    bus.req_wr    = 2'b01;
    bus.req_addr  = {16'h0000, 16'h0055};
    bus.req_wdata = {32'h0, 32'h55555555};
    tick;
    nvec++; if (eth_ctrl_addr !== 32'h00010055) begin nfail++; $display("FAIL rm_strobe got %h exp %h", eth_ctrl_addr, 32'h00010055); end
    tick;
    reset   = 1'b1;
    bus.req = 2'b00;
    tick;
    reset = 1'b0;
    nvec++; if (eth_ctrl_addr !== 32'h0) begin nfail++; $display("FAIL rm_ctrl_addr got %h exp 0", eth_ctrl_addr); end
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL rm_busy got %b exp 0", bus.busy); end
    nvec++; if (eth_wr_data !== 32'h0) begin nfail++; $display("FAIL rm_wr_data got %h exp 0", eth_wr_data); end
    any_ack = (bus.ack !== 2'b00);
    for (int k = 0; k < 12; k++) begin
      tick;
      if (bus.ack !== 2'b00) any_ack = 1'b1;
    end
    nvec++; if (any_ack !== 1'b0) begin nfail++; $display("FAIL rm_no_ack got %b exp 0", any_ack); end
    bus.req       = 2'b01;
    bus.req_addr  = {16'h0000, 16'h0066};
    bus.req_wdata = {32'h0, 32'h66666666};
    tick;
    nvec++; if (eth_ctrl_addr !== 32'h00010066) begin nfail++; $display("FAIL rm_next_strobe got %h exp %h", eth_ctrl_addr, 32'h00010066); end
    lat = 1;
    while (bus.ack === 2'b00 && lat < 40) begin
      tick; lat++;
    end
    nvec++; if (lat != 7) begin nfail++; $display("FAIL rm_next_latency got %0d exp 7", lat); end
    nvec++; if (bus.ack !== 2'b01) begin nfail++; $display("FAIL rm_next_ack got %b exp 01", bus.ack); end
    nvec++; if (eth_wr_data !== 32'h66666666) begin nfail++; $display("FAIL rm_next_wr_data got %h exp %h", eth_wr_data, 32'h66666666); end
    bus.req = 2'b00;
    tick; tick;
  endtask

  task automatic test_hold_through_ack;
    int cyc;
    bus.req       = 2'b01;
    bus.req_wr    = 2'b01;
    bus.req_addr  = {16'h0000, 16'h0077};
    bus.req_wdata = {32'h0, 32'h11111111};
    cyc = 0;
    while (bus.ack === 2'b00 && cyc < 40) begin
      tick; cyc++;
    end
    nvec++; if (bus.ack !== 2'b01) begin nfail++; $display("FAIL hold_first_ack got %b exp 01", bus.ack); end
    tick;
    nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL hold_idle_busy got %b exp 0", bus.busy); end
    nvec++; if (eth_ctrl_addr !== 32'h00000077) begin nfail++; $display("FAIL hold_idle_ctrl got %h exp %h", eth_ctrl_addr, 32'h00000077); end
    tick;
    nvec++; if (eth_ctrl_addr !== 32'h00010077) begin nfail++; $display("FAIL hold_restart got %h exp %h", eth_ctrl_addr, 32'h00010077); end
    cyc = 2;
    while (bus.ack === 2'b00 && cyc < 40) begin
      tick; cyc++;
    end
    nvec++; if (cyc != 8) begin nfail++; $display("FAIL hold_period got %0d exp 8", cyc); end
    nvec++; if (bus.ack !== 2'b01) begin nfail++; $display("FAIL hold_second_ack got %b exp 01", bus.ack); end
    bus.req = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      tick;
      nvec++; if (bus.busy !== 1'b0) begin nfail++; $display("FAIL hold_drop_busy t+%0d got %b exp 0", k, bus.busy); end
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    eth_rd_data   = '0;
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_reset_mid();
    test_hold_through_ack();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
